// File: rtl/fifo_lib_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_lib_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  localparam int RD_LATENCY = 1;
  localparam int BEAT_CNT_W = 32;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer (out + skid) with its occupancy FSM.
// The state encoding doubles as the word count exported on occ.
module fifo_skid_buf
  import fifo_lib_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        occ
);

  occ_state_t        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              pop;

  assign pop   = valid_q & ready;
  assign valid = valid_q;
  assign data  = out_q;
  assign occ   = state_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (cap) begin
          state_d = ONE;
          valid_d = 1'b1;
          out_d   = cap_data;
        end
      end
      ONE: begin
        if (cap && !pop) begin
          state_d = TWO;
          skid_d  = cap_data;
        end else if (pop && !cap) begin
          state_d = EMPTY;
          valid_d = 1'b0;
        end else if (pop && cap) begin
          out_d = cap_data;
        end
      end
      TWO: begin
        // cap without pop cannot occur here: the credit check upstream blocks it
        if (pop) begin
          out_d = skid_q;
          if (cap) skid_d = cap_data;
          else     state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side adapter: credit-gated read enable, one-cycle in-flight
// tracking and a two-entry registered stream output.
// Optional beat counter port enabled by FIFO_RD_ADAPTER_CNT_EN.
module fifo_rd_stream_adapter
  import fifo_lib_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
`ifdef FIFO_RD_ADAPTER_CNT_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_cnt_o
`endif
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic [1:0] credits_used;
  logic [1:0] credits_after;
  logic       pop;

  assign pop = valid_o & ready_i;

  fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .cap      (inflight_q),
    .cap_data (fifo_data_i),
    .ready    (ready_i),
    .valid    (valid_o),
    .data     (data_o),
    .occ      (occ)
  );

  // A read is issued only if the word it returns will have a slot, counting
  // the slot freed by this cycle's pop; this keeps a zero-bubble restart.
  always_comb begin
    credits_used  = occ + {1'b0, inflight_q};
    credits_after = credits_used - {1'b0, pop};
    fifo_rd_en_o  = !rst_i && !fifo_empty_i && (credits_after < 2'd2);
    inflight_d    = fifo_rd_en_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inflight_q <= 1'b0;
    else       inflight_q <= inflight_d;
  end

`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) beat_cnt_q <= '0;
    else       beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter with a behavioural FIFO model.
module tb_fifo_rd_stream_adapter;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
`ifdef FIFO_RD_ADAPTER_CNT_EN
  logic [31:0]   beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .valid_o      (valid),
    .ready_i      (ready),
    .data_o       (data)
`ifdef FIFO_RD_ADAPTER_CNT_EN
    ,
    .beat_cnt_o   (beat_cnt)
`endif
  );

  // FIFO model: registered read data, registered empty flag, one push per cycle
  logic          push_v;
  logic [DW-1:0] push_d;
  logic [DW-1:0] fq[$];

  always @(posedge clk) begin
    if (rst) fq.delete();
    else begin
      if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
      if (push_v) fq.push_back(push_d);
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Outstanding words = issued reads minus pops; must never exceed 2
  int            outst = 0;
  int            cred_err = 0;
  int            cyc = 0;
  logic [DW-1:0] got[$];
  int            got_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) outst <= 0;
    else     outst <= outst + int'(fifo_rd_en) - int'(valid && ready);
  end

  always @(negedge clk) begin
    if (!rst && outst > 2) cred_err <= cred_err + 1;
    if (!rst && valid && ready) begin
      got.push_back(data);
      got_cyc.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; push_v = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic push_words(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      push_v = 1'b1;
      push_d = DW'(first + k);
      tick();
    end
    push_v = 1'b0;
  endtask

  initial begin
    int            base;
    logic [7:0]    rv, vv;
    logic [DW-1:0] dseen, w;
    logic [3:0]    pat;

    rst = 1'b1; ready = 1'b0; push_v = 1'b0; push_d = '0;
    repeat (2) tick();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_rden", fifo_rd_en, 0);
`ifdef FIFO_RD_ADAPTER_CNT_EN
    chk("rst_beat", beat_cnt, 0);
`endif
    rst = 1'b0;

    // idle with empty FIFO
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_valid", valid, 0);
      chk("idle_rden", fifo_rd_en, 0);
      chk("idle_data", data, 0);
    end

    // single word: rd_en one cycle, valid two cycles later for one cycle
    tick();
    ready = 1'b1; push_v = 1'b1; push_d = DW'('hA5);
    tick();
    push_v = 1'b0;
    base = got.size();
    rv = '0; vv = '0; dseen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rv[i] = fifo_rd_en;
      vv[i] = valid;
      if (valid) dseen = data;
    end
    chk("single_rden_trace", rv, 8'h01);
    chk("single_valid_trace", vv, 8'h04);
    chk("single_data", dseen, DW'('hA5));
    chk("single_count", got.size() - base, 1);

    // streaming 64 words with ready held high
    do_reset();
    ready = 1'b1;
    base = got.size();
    push_words(0, 64);
    for (int i = 0; i < 40 && got.size() - base < 64; i++) tick();
    chk("stream_count", got.size() - base, 64);
    for (int i = 0; i < 64; i++) begin
      w = (base + i < got.size()) ? got[base + i] : '1;
      chk("stream_data", w, DW'(i));
    end
    if (got.size() - base >= 64)
      chk("stream_consecutive", got_cyc[base + 63] - got_cyc[base], 63);
    else
      chk("stream_consecutive", 0, 63);
`ifdef FIFO_RD_ADAPTER_CNT_EN
    chk("stream_beat_cnt", beat_cnt, 64);
`endif

    // back-pressure: 1-0-0-1 pattern with random extra stalls
    do_reset();
    base = got.size();
    push_words('h100, 16);
    pat = 4'b1001;
    for (int i = 0; i < 400 && got.size() - base < 16; i++) begin
      ready = pat[i % 4] && ($urandom_range(0, 3) != 0);
      tick();
    end
    ready = 1'b0;
    repeat (6) tick();
    chk("bp_count", got.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      w = (base + i < got.size()) ? got[base + i] : '1;
      chk("bp_data", w, DW'('h100 + i));
    end
    chk("bp_credits", cred_err, 0);

    // stall with FIFO holding words, then release
    do_reset();
    push_words('h20, 6);
    repeat (6) tick();
    @(negedge clk);
    chk("stall_valid", valid, 1);
    chk("stall_data", data, DW'('h20));
    chk("stall_rden", fifo_rd_en, 0);
    chk("stall_outstanding", outst, 2);
    tick();
    ready = 1'b1;
    @(negedge clk);
    chk("restart_rden", fifo_rd_en, 1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("release_valid", valid, 1);
      chk("release_data", data, DW'('h20 + k));
    end
    tick();
    ready = 1'b0;

    // reset mid-burst with a word held and another in flight
    do_reset();
    push_words('h40, 3);
    @(negedge clk);
    for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
    chk("midrst_valid_seen", valid, 1);
    chk("midrst_outstanding", outst, 2);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid_now", valid, 0);
    chk("midrst_rden_now", fifo_rd_en, 0);
    chk("midrst_data_now", data, 0);
    tick();
    tick();
    rst = 1'b0;
    ready = 1'b1;
    base = got.size();
    push_words('h7, 1);
    repeat (8) tick();
    chk("midrst_count", got.size() - base, 1);
    w = (base < got.size()) ? got[base] : '1;
    chk("midrst_first", w, DW'('h7));
    chk("final_credits", cred_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
